// File: rtl/dma_controller.sv
// OAM DMA engine: copies 160 bytes from {src_hi,8'h00} into OAM, arbitrating the CPU bus.
// Optional macro DMA_RESTART_EN: a write to 16'hFF46 during a transfer restarts it.
module dma_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] A_cpu,
  input  logic [7:0]  Di_cpu,
  output logic [7:0]  Do_cpu,
  input  logic        rd_cpu_n,
  input  logic        wr_cpu_n,
  output logic [15:0] A_mem,
  output logic [7:0]  Do_mem,
  input  logic [7:0]  Di_mem,
  output logic        rd_mem_n,
  output logic        wr_mem_n,
  output logic [7:0]  A_oam,
  output logic [7:0]  Do_oam,
  output logic        wr_oam_n,
  output logic        dma_active,
  output logic        dma_done
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam logic [AW-1:0] DMA_REG  = 16'hFF46;
  localparam logic [AW-1:0] HRAM_LO  = 16'hFF80;
  localparam logic [AW-1:0] HRAM_HI  = 16'hFFFE;
  localparam logic [DW-1:0] LAST_IDX = 8'd159;
  localparam logic [DW-1:0] ECHO_LO  = 8'hE0;
  localparam logic [DW-1:0] ECHO_OFS = 8'h20;

  typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] src_hi_q, src_hi_d;
  logic [DW-1:0] idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
  logic          done_d;
  logic          dma_active_q, dma_done_q, wr_oam_n_q;
  logic [DW-1:0] a_oam_q, do_oam_q;

  logic          hram_c;
  logic          reg_wr_c;
  logic [DW-1:0] src_eff_c;

  // CPU request decode; echo RAM pages fold back onto WRAM
  always_comb begin
    hram_c    = (!rd_cpu_n || !wr_cpu_n) && (A_cpu >= HRAM_LO) && (A_cpu <= HRAM_HI);
    reg_wr_c  = !wr_cpu_n && (A_cpu == DMA_REG);
    src_eff_c = (src_hi_q >= ECHO_LO) ? DW'(src_hi_q - ECHO_OFS) : src_hi_q;
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    src_hi_d = src_hi_q;
    idx_d    = idx_q;
    data_d   = data_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (reg_wr_c) begin
          state_d  = START;
          src_hi_d = Di_cpu;
          idx_d    = '0;
        end
      end
      START: state_d = READ;
      READ: begin
        if (!hram_c) begin
          data_d  = Di_mem;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = DW'(idx_q + 8'd1);
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef DMA_RESTART_EN
    if (state_q != IDLE && reg_wr_c) begin
      state_d  = START;
      src_hi_d = Di_cpu;
      idx_d    = '0;
      done_d   = 1'b0;
    end
`endif
  end

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      src_hi_q     <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      dma_active_q <= 1'b0;
      dma_done_q   <= 1'b0;
      wr_oam_n_q   <= 1'b1;
      a_oam_q      <= '0;
      do_oam_q     <= '0;
    end else begin
      state_q      <= state_d;
      src_hi_q     <= src_hi_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      dma_active_q <= (state_d != IDLE);
      dma_done_q   <= done_d;
      wr_oam_n_q   <= (state_d != WRITE);
      a_oam_q      <= idx_d;
      do_oam_q     <= data_d;
    end
  end

  assign dma_active = dma_active_q;
  assign dma_done   = dma_done_q;
  assign wr_oam_n   = wr_oam_n_q;
  assign A_oam      = a_oam_q;
  assign Do_oam     = do_oam_q;

  // Bus mux: CPU passes through when idle or touching HRAM; otherwise DMA owns the bus
  always_comb begin
    A_mem    = A_cpu;
    Do_mem   = Di_cpu;
    rd_mem_n = rd_cpu_n;
    wr_mem_n = wr_cpu_n;
    Do_cpu   = Di_mem;
    if (state_q != IDLE && !hram_c) begin
      rd_mem_n = 1'b1;
      wr_mem_n = 1'b1;
      Do_cpu   = 8'hFF;
      if (state_q == READ) begin
        A_mem    = {src_eff_c, idx_q};
        rd_mem_n = 1'b0;
      end
    end
    if (A_cpu == DMA_REG) Do_cpu = src_hi_q;
  end

endmodule

// File: tb/tb_dma_controller.sv
// Directed/randomized bench for dma_controller with a memory model and an OAM shadow.
module tb_dma_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] A_cpu;
  logic [7:0]  Di_cpu, Do_cpu;
  logic        rd_cpu_n, wr_cpu_n;
  logic [15:0] A_mem;
  logic [7:0]  Do_mem, Di_mem;
  logic        rd_mem_n, wr_mem_n;
  logic [7:0]  A_oam, Do_oam;
  logic        wr_oam_n, dma_active, dma_done;

  dma_controller dut (
    .clock(clock), .reset(reset),
    .A_cpu(A_cpu), .Di_cpu(Di_cpu), .Do_cpu(Do_cpu), .rd_cpu_n(rd_cpu_n), .wr_cpu_n(wr_cpu_n),
    .A_mem(A_mem), .Do_mem(Do_mem), .Di_mem(Di_mem), .rd_mem_n(rd_mem_n), .wr_mem_n(wr_mem_n),
    .A_oam(A_oam), .Do_oam(Do_oam), .wr_oam_n(wr_oam_n),
    .dma_active(dma_active), .dma_done(dma_done)
  );

  always #5 clock = ~clock;

  // Memory controller model and OAM/bus monitors
  logic [7:0]  mem    [0:65535];
  logic [7:0]  oam    [0:255];
  logic [15:0] rd_log [0:2047];
  int unsigned act_cnt, done_cnt, oam_wr_cnt, rd_cnt;

  assign Di_mem = mem[A_mem];

  always @(posedge clock) begin
    if (!reset) begin
      if (!wr_mem_n) mem[A_mem] <= Do_mem;
      if (dma_active) act_cnt <= act_cnt + 1;
      if (dma_done) done_cnt <= done_cnt + 1;
      if (!wr_oam_n) begin
        oam[A_oam] <= Do_oam;
        oam_wr_cnt <= oam_wr_cnt + 1;
      end
      if (dma_active && !rd_mem_n && !(A_mem >= 16'hFF80 && A_mem <= 16'hFFFE)) begin
        rd_log[rd_cnt[10:0]] <= A_mem;
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  int unsigned checks, failures;
  logic [7:0]  shadow [0:65535];
  logic [7:0]  prev_oam [0:159];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_idle();
    A_cpu = 16'h0000; Di_cpu = 8'h00; rd_cpu_n = 1'b1; wr_cpu_n = 1'b1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    A_cpu = a; Di_cpu = d; rd_cpu_n = 1'b1; wr_cpu_n = 1'b0;
    tick();
    cpu_idle();
  endtask

  // Load 160 bytes at {page,00} through the idle pass-through path
  task automatic fill(input logic [7:0] page, input bit ramp);
    logic [7:0] d;
    for (int i = 0; i < 160; i++) begin
      d = ramp ? 8'(i) : 8'($urandom);
      shadow[{page, 8'(i)}] = d;
      cpu_write({page, 8'(i)}, d);
    end
  endtask

  // Reference: OAM[lo..hi] equals the 160-byte source block, echo pages minus 0x20
  task automatic check_oam(input string tag, input logic [7:0] src, input int lo, input int hi);
    logic [7:0] base;
    int bad;
    base = (src >= 8'hE0) ? 8'(src - 8'h20) : src;
    bad = 0;
    for (int i = lo; i <= hi; i++)
      if (oam[i] !== shadow[{base, 8'(i)}]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int unsigned snap;
    int n;
    snap = done_cnt;
    n = 0;
    while (done_cnt == snap && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(done_cnt != snap), 32'd1);
  endtask

  task automatic wait_oam(input string tag, input int unsigned snap, input int unsigned target);
    int n;
    n = 0;
    while ((oam_wr_cnt - snap) < target && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, oam_wr_cnt - snap, target);
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    A_cpu = a; rd_cpu_n = 1'b0; wr_cpu_n = 1'b1;
    #1;
    chk(tag, 32'(Do_cpu), 32'(exp));
    tick();
    cpu_idle();
  endtask

  initial begin
    int unsigned s_act, s_done, s_oam, s_rd;
    int bad, n, bad_bus;
    logic [7:0] hval;

    cpu_idle();
    reset = 1'b1;
    tick(); tick();
    chk("rst_active", 32'(dma_active), 32'd0);
    chk("rst_done", 32'(dma_done), 32'd0);
    chk("rst_wr_oam_n", 32'(wr_oam_n), 32'd1);
    chk("rst_a_oam", 32'(A_oam), 32'd0);
    chk("rst_do_oam", 32'(Do_oam), 32'd0);
    reset = 1'b0;
    tick();
    read_chk("rst_ff46", 16'hFF46, 8'h00);

    // Basic transfer, ramp data
    fill(8'hC1, 1'b1);
    read_chk("idle_passthru_rd", 16'hC105, 8'h05);
    s_act = act_cnt; s_done = done_cnt; s_oam = oam_wr_cnt; s_rd = rd_cnt;
    cpu_write(16'hFF46, 8'hC1);
    wait_done("basic_done_seen", 1000);
    tick(); tick(); tick();
    chk("basic_active_cycles", act_cnt - s_act, 32'd321);
    chk("basic_done_pulses", done_cnt - s_done, 32'd1);
    chk("basic_oam_writes", oam_wr_cnt - s_oam, 32'd160);
    check_oam("basic_oam_data", 8'hC1, 0, 159);
    read_chk("basic_ff46", 16'hFF46, 8'hC1);

    // Echo-RAM source
    fill(8'hC1, 1'b0);
    s_rd = rd_cnt;
    cpu_write(16'hFF46, 8'hE1);
    wait_done("echo_done_seen", 1000);
    tick();
    chk("echo_read_count", rd_cnt - s_rd, 32'd160);
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (rd_log[11'(s_rd + 32'(i))] !== 16'hC100 + 16'(i)) bad++;
    chk("echo_read_addrs", 32'(bad), 32'd0);
    check_oam("echo_oam_data", 8'hE1, 0, 159);
    read_chk("echo_ff46", 16'hFF46, 8'hE1);

    // HRAM stall for 10 cycles
    hval = 8'($urandom);
    cpu_write(16'hFF85, hval);
    fill(8'hD2, 1'b0);
    s_act = act_cnt;
    cpu_write(16'hFF46, 8'hD2);
    repeat (17) tick();
    n = 0;
    while (!(dma_active && !rd_mem_n) && n < 10) begin
      tick();
      n++;
    end
    chk("hram_found_read", 32'(dma_active && !rd_mem_n), 32'd1);
    s_oam = oam_wr_cnt;
    bad = 0; bad_bus = 0;
    for (int k = 0; k < 10; k++) begin
      A_cpu = 16'hFF85; rd_cpu_n = 1'b0;
      #1;
      if (Do_cpu !== hval) bad++;
      if (A_mem !== 16'hFF85) bad_bus++;
      tick();
    end
    cpu_idle();
    chk("hram_cpu_data", 32'(bad), 32'd0);
    chk("hram_cpu_addr", 32'(bad_bus), 32'd0);
    chk("hram_dma_stalled", oam_wr_cnt - s_oam, 32'd0);
    wait_done("hram_done_seen", 1000);
    tick();
    chk("hram_active_cycles", act_cnt - s_act, 32'd331);
    check_oam("hram_oam_data", 8'hD2, 0, 159);

    // Blocked non-HRAM CPU accesses
    cpu_write(16'hC000, 8'hAA);
    shadow[16'hC000] = 8'hAA;
    fill(8'hC3, 1'b0);
    cpu_write(16'hFF46, 8'hC3);
    repeat (20) tick();
    read_chk("block_rd", 16'hC000, 8'hFF);
    A_cpu = 16'hC000; Di_cpu = 8'h55; wr_cpu_n = 1'b0;
    #1;
    chk("block_wr_mem_n", 32'(wr_mem_n), 32'd1);
    tick();
    cpu_idle();
    wait_done("block_done_seen", 1000);
    tick();
    read_chk("block_c000_kept", 16'hC000, 8'hAA);
    check_oam("block_oam_data", 8'hC3, 0, 159);

    // FF46 write at idx 40
    fill(8'hC4, 1'b0);
    fill(8'hD0, 1'b0);
    s_done = done_cnt; s_oam = oam_wr_cnt;
    cpu_write(16'hFF46, 8'hC4);
    wait_oam("restart_reach_40", s_oam, 32'd40);
    cpu_write(16'hFF46, 8'hD0);
    wait_done("restart_done_seen", 1000);
    repeat (5) tick();
    chk("restart_done_pulses", done_cnt - s_done, 32'd1);
`ifdef DMA_RESTART_EN
    check_oam("restart_oam_data", 8'hD0, 0, 159);
    read_chk("restart_ff46", 16'hFF46, 8'hD0);
`else
    check_oam("restart_oam_data", 8'hC4, 0, 159);
    read_chk("restart_ff46", 16'hFF46, 8'hC4);
`endif

    // Reset at idx 80
    for (int i = 0; i < 160; i++) prev_oam[i] = oam[i];
    fill(8'hC5, 1'b0);
    s_done = done_cnt; s_oam = oam_wr_cnt;
    cpu_write(16'hFF46, 8'hC5);
    wait_oam("abort_reach_80", s_oam, 32'd80);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_active", 32'(dma_active), 32'd0);
    chk("abort_done", 32'(dma_done), 32'd0);
    chk("abort_wr_oam_n", 32'(wr_oam_n), 32'd1);
    chk("abort_a_oam", 32'(A_oam), 32'd0);
    chk("abort_do_oam", 32'(Do_oam), 32'd0);
    chk("abort_rd_mem_n", 32'(rd_mem_n), 32'd1);
    tick(); tick();
    reset = 1'b0;
    repeat (400) tick();
    chk("abort_oam_writes", oam_wr_cnt - s_oam, 32'd80);
    chk("abort_no_done", done_cnt - s_done, 32'd0);
    check_oam("abort_oam_low", 8'hC5, 0, 79);
    bad = 0;
    for (int i = 80; i < 160; i++)
      if (oam[i] !== prev_oam[i]) bad++;
    chk("abort_oam_high_kept", 32'(bad), 32'd0);
    read_chk("abort_ff46", 16'hFF46, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_controller.md
DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 The module SHALL have the port clock, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-002 The module SHALL have the port reset, input, 1 bit, asynchronous active-high reset.
REQ-003 The module SHALL have the CPU-side ports A_cpu (input, 16), Di_cpu (input, 8, data from CPU), Do_cpu (output, 8, data to CPU), rd_cpu_n (input, 1) and wr_cpu_n (input, 1).
REQ-004 The module SHALL have the bus-side ports to memory_controller: A_mem (output, 16), Do_mem (output, 8), Di_mem (input, 8), rd_mem_n (output, 1) and wr_mem_n (output, 1).
REQ-005 The module SHALL have the OAM write port: A_oam (output, 8, OAM byte index), Do_oam (output, 8) and wr_oam_n (output, 1).
REQ-006 The module SHALL have the status outputs dma_active (output, 1, transfer in progress) and dma_done (output, 1, single-cycle completion pulse).

Function
REQ-007 The FSM SHALL have the states IDLE, START, READ and WRITE.
REQ-008 In IDLE, the CPU bus SHALL pass through combinationally: A_mem=A_cpu, Do_mem=Di_cpu, rd_mem_n=rd_cpu_n, wr_mem_n=wr_cpu_n, and Do_cpu=Di_mem.
REQ-009 When a CPU access to 16'hFF46 is sampled at a clock edge with wr_cpu_n=0, the block SHALL latch Di_cpu into src_hi, clear idx to 0 and enter START.
REQ-010 A CPU read of 16'hFF46 SHALL return src_hi on Do_cpu in every state.
REQ-011 START SHALL last one cycle and then go to READ; dma_active SHALL be high in START, READ and WRITE.
REQ-012 In READ, the block SHALL drive A_mem={src_eff,idx}, rd_mem_n=0 and wr_mem_n=1, and SHALL capture Di_mem into data_q at the clock edge.
REQ-013 src_eff SHALL be src_hi-8'h20 when src_hi>=8'hE0 (echo RAM) and src_hi otherwise.
REQ-014 In WRITE, the block SHALL drive A_oam=idx, Do_oam=data_q and wr_oam_n=0, and the bus SHALL be idle (rd_mem_n=wr_mem_n=1).
REQ-015 At the end of a WRITE cycle, idx SHALL increment and the FSM SHALL return to READ; when idx=159, the FSM SHALL go to IDLE and pulse dma_done for one cycle.
REQ-016 A full transfer SHALL be 160 bytes taking 320 cycles, so dma_active is high for 321 cycles including START.
REQ-017 HRAM arbitration: in READ, when A_cpu is in 16'hFF80..16'hFFFE, the CPU SHALL own the bus that cycle (pass-through per REQ-008), and the DMA SHALL stall in READ with idx and data_q held.
REQ-018 The CPU SHALL have priority in every stall cycle, and the DMA SHALL resume on the first cycle without an HRAM access.
REQ-019 During dma_active, a CPU access outside HRAM SHALL be blocked: reads return 8'hFF, writes are not forwarded (wr_mem_n stays 1). The only exception is a write to 16'hFF46, which is handled by REQ-024.
REQ-020 In WRITE, CPU HRAM accesses SHALL pass through without stalling.
REQ-021 wr_oam_n SHALL be 0 only in WRITE.

Reset
REQ-022 While reset is high, the block SHALL asynchronously force: state=IDLE, src_hi=8'h00, idx=0, data_q=8'h00, dma_active=0, dma_done=0, wr_oam_n=1, A_oam=8'h00 and Do_oam=8'h00.
REQ-023 If reset is asserted during a transfer, the transfer SHALL be aborted, OAM SHALL receive no further writes, and no dma_done SHALL be produced.

Configuration
REQ-024 The macro DMA_RESTART_EN SHALL control writes to 16'hFF46 while dma_active is high. When defined, such a write reloads src_hi, clears idx and enters START with no dma_done for the aborted transfer. When undefined, such a write is ignored: src_hi is unchanged and the transfer continues.

Verification
REQ-025 Write 8'hC1 to FF46 with wram C100+i=i -> OAM i=i for i=0..159; dma_active high for 321 cycles; one dma_done pulse.
REQ-026 Write 8'hE1 to FF46 -> A_mem read addresses are C100..C19F.
REQ-027 CPU reads FF85 for 10 consecutive cycles during READ -> CPU gets HRAM data; transfer end delayed exactly 10 cycles; OAM contents correct.
REQ-028 CPU reads C000 / writes C000=8'h55 mid-transfer -> read returns 8'hFF; wr_mem_n stays 1; C000 unchanged.
REQ-029 Write 8'hD0 to FF46 at idx=40 -> with DMA_RESTART_EN: OAM 0..159 from D000.., single dma_done; without: OAM from original source, FF46 still reads the original source value.
REQ-030 Assert reset at idx=80 -> outputs at reset values immediately; OAM 80..159 unwritten; no dma_done.
